// File: rtl/bus_arbiter.sv
// bus_arbiter: 5-master round-robin arbiter with registered one-hot grant.
// Define BUS_ARB_TIMEOUT_EN to limit a tenure to HOLD_MAX cycles with a timeout pulse.
module bus_arbiter #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req,
  output logic [4:0] grant,
  output logic [2:0] owner,
  output logic       busy,
  output logic       timeout
);
  typedef enum logic {IDLE, OWNED} state_t;
  state_t     state;
  logic [2:0] ptr, o1, nidx;
  logic [4:0] r;
  logic [3:0] w;
  logic       keep, force_rel, go;
  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_range
    $error("bus_arbiter: HOLD_MAX must be within 2..255");
  end
  // {found, index} of the first set bit of m scanning s, s+1, ... mod 5
  function automatic logic [3:0] pick(input logic [4:0] m, input logic [2:0] s);
    logic [3:0] t;
    logic [2:0] j;
    pick = 4'd0;
    for (int k = 4; k >= 0; k--) begin
      t = {1'b0, s} + 4'(k);
      j = 3'(t >= 4'd5 ? t - 4'd5 : t);
      if (m[j]) pick = {1'b1, j};
    end
  endfunction
  assign r    = {req[0], req[1], req[2], req[3], req[4]};
  assign o1   = owner == 3'd4 ? 3'd0 : owner + 3'd1;
  assign keep = state == OWNED && r[owner];
  assign w    = pick(r, state == OWNED ? o1 : ptr);
  assign go   = keep || w[3];
`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0] cnt;
  logic [3:0] f;
  assign f         = pick(r & ~(5'b00001 << owner), o1);
  assign force_rel = keep && cnt == 8'(HOLD_MAX - 1);
  assign nidx      = force_rel ? (f[3] ? f[2:0] : owner) : keep ? owner : w[2:0];
  always_ff @(posedge clk)
    cnt <= (rst || !keep || force_rel) ? 8'd0 : cnt + 8'd1;
`else
  assign force_rel = 1'b0;
  assign nidx      = keep ? owner : w[2:0];
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state   <= IDLE;
      grant   <= 5'd0;
      owner   <= 3'd0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      ptr     <= 3'd0;
    end else begin
      state   <= go ? OWNED : IDLE;
      grant   <= go ? 5'b10000 >> nidx : 5'd0;
      owner   <= go ? nidx : 3'd0;
      busy    <= go;
      timeout <= force_rel;
      if (state == OWNED && (!keep || force_rel)) ptr <= o1;
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and random checks of bus_arbiter against a behavioural model.
module tb_bus_arbiter;
  localparam int HM = 4;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] req = 5'd0;
  logic [4:0] grant;
  logic [2:0] owner;
  logic       busy, timeout;
  int total = 0;
  int bad = 0;
  int own = -1;
  int ptr = 0;
  int hc = 0;
  logic mto = 1'b0;
  int seq[$];
  int last;
  logic [4:0] rv;
  logic rr;
  bus_arbiter #(.HOLD_MAX(HM)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant),
    .owner(owner), .busy(busy), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  function automatic int srch(input logic [4:0] rq, input int s, input int ex);
    for (int k = 0; k < 5; k++) begin
      int m = (s + k) % 5;
      if (m != ex && rq[4-m]) return m;
    end
    return -1;
  endfunction
  // hc counts grant cycles of the current tenure, starting at 1
  task automatic mstep(input logic [4:0] rq, input logic rs);
    mto = 1'b0;
    if (rs) begin
      own = -1; ptr = 0; hc = 0;
    end else if (own < 0) begin
      own = srch(rq, ptr, -1); hc = 1;
    end else if (!rq[4-own]) begin
      ptr = (own + 1) % 5; own = srch(rq, ptr, -1); hc = 1;
    end
`ifdef BUS_ARB_TIMEOUT_EN
    else if (hc == HM) begin
      int nw;
      ptr = (own + 1) % 5;
      nw = srch(rq, ptr, own);
      if (nw >= 0) own = nw;
      hc = 1; mto = 1'b1;
    end
`endif
    else hc++;
  endtask
  task automatic cyc(input logic [4:0] r, input logic rs);
    req = r; rst = rs;
    @(posedge clk);
    mstep(r, rs);
    #1;
    chk("grant", 8'(grant), own < 0 ? 8'd0 : 8'(5'b10000 >> own));
    chk("owner", 8'(owner), own < 0 ? 8'd0 : 8'(own));
    chk("busy", 8'(busy), 8'(own >= 0));
    chk("timeout", 8'(timeout), 8'(mto));
    chk("onehot", 8'($countones(grant) <= 1), 8'd1);
  endtask
  initial begin
    cyc(5'b00000, 1'b1);
    chk("rst_grant", 8'(grant), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    cyc(5'b00100, 1'b0);
    chk("r026_grant", 8'(grant), 8'h04);
    chk("r026_owner", 8'(owner), 8'd2);
    chk("r026_busy", 8'(busy), 8'd1);
    cyc(5'b01000, 1'b0);
    chk("r029_pre", 8'(grant), 8'h08);
    cyc(5'b01000, 1'b1);
    chk("r029_grant", 8'(grant), 8'h00);
    chk("r029_busy", 8'(busy), 8'h00);
    cyc(5'b01001, 1'b0);
    chk("r029_after", 8'(grant), 8'h08);
    cyc(5'b00000, 1'b1);
    cyc(5'b00010, 1'b0);
    chk("r028_own3", 8'(grant), 8'h02);
    for (int i = 0; i < 3; i++) begin
      cyc(5'b10010, 1'b0);
      chk("r028_hold", 8'(grant), 8'h02);
    end
    cyc(5'b10000, 1'b0);
    chk("r028_next", 8'(grant), 8'h10);
    cyc(5'b10001, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      cyc(5'b10001, 1'b0);
`ifdef BUS_ARB_TIMEOUT_EN
      chk("r030_grant", 8'(grant), (i >= 5 && i <= 8) ? 8'h01 : 8'h10);
      chk("r030_to", 8'(timeout), 8'(i == 5 || i == 9));
`else
      chk("r031_grant", 8'(grant), 8'h10);
      chk("r031_to", 8'(timeout), 8'h00);
`endif
    end
    cyc(5'b11111, 1'b1);
    last = -1;
    for (int i = 0; i < 18; i++) begin
      rv = (own >= 0 && hc == 3) ? 5'b11111 & ~(5'b10000 >> own) : 5'b11111;
      cyc(rv, 1'b0);
      chk("r027_busy", 8'(busy), 8'd1);
      if (int'(owner) != last) begin
        seq.push_back(int'(owner));
        last = int'(owner);
      end
    end
    chk("r027_len", 8'(seq.size()), 8'd6);
    for (int i = 0; i < 6; i++)
      chk("r027_order", i < seq.size() ? 8'(seq[i]) : 8'hff, 8'(i % 5));
    rv = 5'($urandom);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) rv = rv ^ 5'(1 << $urandom_range(0, 4));
      rr = $urandom_range(0, 199) == 0;
      cyc(rv, rr);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, default 16, maximum consecutive grant cycles per tenure (used only with BUS_ARB_TIMEOUT_EN; legal range 2..255).
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: req  input  5  bus requests; master i drives bit 4-i (master 0 = req[4] ... master 4 = req[0]).
REQ-005 Port: grant  output  5  registered one-hot grant; master i owns the bus when grant = 5'b10000 >> i; 5'b00000 = no owner.
REQ-006 Port: owner  output  3  registered index 0..4 of current owner; 3'd0 when idle.
REQ-007 Port: busy  output  1  registered; high exactly when grant != 0.
REQ-008 Port: timeout  output  1  registered one-cycle pulse on forced release; constant 0 without BUS_ARB_TIMEOUT_EN.
REQ-009 grant drives the select of the downstream 5-input one-hot data mux directly; grant = 0 selects that mux's zero default.

Function
REQ-010 States: IDLE (grant = 0) and OWNED (exactly one grant bit set); grant SHALL never have more than one bit set.
REQ-011 Round-robin pointer ptr (0..4): search order ptr, ptr+1, ... mod 5; first master with req high wins.
REQ-012 IDLE: any req high -> OWNED next edge, grant to winner; req = 0 -> stay IDLE.
REQ-013 Request-to-grant latency: exactly 1 clock from first edge sampling req high while IDLE.
REQ-014 OWNED: owner's req high -> grant, owner unchanged.
REQ-015 OWNED, owner's req low: ptr <= owner+1 mod 5; next edge grant to winner of search from owner+1 among current req, else IDLE (grant = 0); no idle bubble between tenures.
REQ-016 Requests from non-owners never preempt an owner (except REQ-024).
REQ-017 ptr updates only at release (REQ-015) or forced release (REQ-024); it is not updated on grant.
REQ-018 owner and busy SHALL be consistent with grant on the same cycle.
REQ-019 Requests pulsed low-high between edges are not seen; only edge-sampled req matters.

Reset
REQ-020 rst high at an edge: grant = 0, owner = 0, busy = 0, timeout = 0, ptr = 0, hold counter = 0, state IDLE; overrides all other events that edge.
REQ-021 Reset mid-tenure drops grant on that edge; first grant after rst deasserts follows REQ-012/013 with ptr = 0.

Configuration
REQ-022 Macro BUS_ARB_TIMEOUT_EN compiles in the tenure-limit feature.
REQ-023 With macro: 8-bit hold counter cleared on each new grant, increments each OWNED cycle.
REQ-024 With macro: owner's HOLD_MAX-th consecutive grant cycle with req still high -> next edge: ptr <= owner+1, grant to winner of search excluding owner, timeout = 1 for one cycle; no other requester -> owner regranted, counter cleared, timeout still pulses.
REQ-025 Without macro: no counter, tenure unbounded, timeout tied 0, HOLD_MAX ignored.

Verification
REQ-026 rst 1 cycle, req = 5'b00100 -> next edge grant = 5'b00100, owner = 2, busy = 1.
REQ-027 req = 5'b11111 after reset, each owner drops req for 1 cycle on its 3rd grant cycle, then reasserts -> owners 0,1,2,3,4,0 in order, no idle cycle between.
REQ-028 Owner 3 (grant 5'b00010) holds, req = 5'b10010 -> grant stays 5'b00010 until req[1] drops, then 5'b10000 next edge.
REQ-029 rst asserted while grant = 5'b01000 -> grant = 0, busy = 0 same edge; req = 5'b01001 after release -> grant = 5'b01000 (ptr = 0).
REQ-030 Macro on, HOLD_MAX = 4, req = 5'b10001 held -> master 0 owns 4 cycles, timeout pulse, grant 5'b00001 for 4 cycles, then back to 5'b10000.
REQ-031 Macro off, same stimulus -> grant 5'b10000 indefinitely, timeout = 0 throughout.
